// File: rtl/pe_merge_pkg.sv
// Shared types for the partial-sum merge stage: FSM states and saturation helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pe_merge_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,   // no node open
      ST_ACCUM = 1'b1    // cur_node/acc hold an open node
   } state_t;

   // Direction of a signed overflow on a one-bit-wider sum.
   typedef enum logic [1:0] {
      SAT_NONE = 2'd0,
      SAT_POS  = 2'd1,
      SAT_NEG  = 2'd2
   } sat_t;

   // guard_bit is the extra MSB of a sum one bit wider than the result,
   // sign_bit is the result MSB. When they differ the result has left range;
   // the guard bit carries the true sign.
   function automatic sat_t sat_dir(input logic guard_bit, input logic sign_bit);
      if (guard_bit == sign_bit) begin
         return SAT_NONE;
      end
      return guard_bit ? SAT_NEG : SAT_POS;
   endfunction

endpackage

// File: rtl/log2.vh
// Shared width helper: C_LOG_2(n) = bits needed to index n items (minimum 1).
// Latency: n/a (constant expression only).
// Backpressure: n/a.
`ifndef LOG2_VH
`define LOG2_VH
`define C_LOG_2(n) (((n) <= 1) ? 1 : $clog2(n))
`endif

// File: rtl/psum_fifo.sv
// Synchronous result FIFO holding {node, sum} words; push and pop in one cycle allowed even when full.
// Latency: a push at edge N is visible at the head after edge N when the FIFO was empty.
// Backpressure: a push while full without a same-cycle pop is ignored; the caller flags the loss.
//
// Ports: clk, reset (sync, active-high); push/push_dat write side;
//        pop/pop_dat read side (pop_dat is the head entry); full, empty status.
//        DEPTH must be a power of 2, at least 2.
module psum_fifo #(
   parameter int DAT_W = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [DAT_W-1:0] push_dat,
   input  logic             pop,
   output logic [DAT_W-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [DAT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
   assign do_push = push && (!full || do_pop);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pe_psum_merge.sv
// Merges the PE tile's tagged partial-sum stream into one signed sum per node and queues {node, sum} results.
// Latency: in_vd & in_last at edge N gives out_vd=1 after edge N when the result FIFO was empty.
// Backpressure: input is never stalled; a result arriving at a full FIFO with no pop is dropped and sets overflow.
//
// Ports: clk, reset (sync, active-high);
//        in_data/in_vd/in_node/in_last   partial-sum stream from the PE tile;
//        out_vd/out_ready/out_data/out_node  result stream (head of result FIFO);
//        overflow, node_err               sticky error flags, cleared only by reset.
// Build option: define PSUM_SATURATE_EN to clamp each add to the signed ACC_WIDTH range
//               (default: adds wrap modulo 2^ACC_WIDTH).
`include "log2.vh"

module pe_psum_merge
   import pe_merge_pkg::*;
#(
   parameter int PE_OUT_WIDTH = 8,
   parameter int ACC_WIDTH    = 16,
   parameter int NUM_NODES    = 20,
   parameter int NODE_W       = `C_LOG_2(NUM_NODES),
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PE_OUT_WIDTH-1:0] in_data,
   input  logic                    in_vd,
   input  logic [NODE_W-1:0]       in_node,
   input  logic                    in_last,
   input  logic                    out_ready,
   output logic                    out_vd,
   output logic [ACC_WIDTH-1:0]    out_data,
   output logic [NODE_W-1:0]       out_node,
   output logic                    overflow,
   output logic                    node_err
);

   state_t                 state_q;
   state_t                 state_d;
   logic [ACC_WIDTH-1:0]   acc_q;
   logic [ACC_WIDTH-1:0]   acc_d;
   logic [NODE_W-1:0]      cur_q;
   logic [NODE_W-1:0]      cur_d;
   logic                   add_cont;
   logic [ACC_WIDTH-1:0]   in_ext;
   logic [ACC_WIDTH-1:0]   add_base;
   logic [ACC_WIDTH-1:0]   sum_res;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;
   logic                   err_set;

   assign in_ext = ACC_WIDTH'($signed(in_data));

   // A partial only adds onto acc when it continues the open node; a fresh or
   // re-tagged node starts from zero, which discards any abandoned partial.
   assign add_cont = (state_q == ST_ACCUM) && (in_node == cur_q);
   assign add_base = add_cont ? acc_q : '0;

`ifdef PSUM_SATURATE_EN
   logic [ACC_WIDTH:0] sum_wide;

   assign sum_wide = {add_base[ACC_WIDTH-1], add_base} + {in_ext[ACC_WIDTH-1], in_ext};

   always_comb begin
      sum_res = sum_wide[ACC_WIDTH-1:0];
      unique case (sat_dir(sum_wide[ACC_WIDTH], sum_wide[ACC_WIDTH-1]))
         SAT_POS: sum_res = {1'b0, {(ACC_WIDTH-1){1'b1}}};
         SAT_NEG: sum_res = {1'b1, {(ACC_WIDTH-1){1'b0}}};
         default: sum_res = sum_wide[ACC_WIDTH-1:0];
      endcase
   end
`else
   assign sum_res = add_base + in_ext;
`endif

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cur_d   = cur_q;
      push    = 1'b0;
      err_set = 1'b0;
      if (in_vd) begin
         acc_d   = sum_res;
         cur_d   = in_node;
         err_set = (state_q == ST_ACCUM) && (in_node != cur_q);
         if (in_last) begin
            push    = 1'b1;
            state_d = ST_IDLE;
         end else begin
            state_d = ST_ACCUM;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         cur_q    <= '0;
         overflow <= 1'b0;
         node_err <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cur_q <= cur_d;
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end
         if (err_set) begin
            node_err <= 1'b1;
         end
      end
   end

   assign out_vd = !empty;
   assign pop    = out_vd && out_ready;

   // in_node equals cur_q whenever a continuing node closes, so it tags every push.
   psum_fifo #(
      .DAT_W (NODE_W + ACC_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat ({in_node, sum_res}),
      .pop      (pop),
      .pop_dat  ({out_node, out_data}),
      .full     (full),
      .empty    (empty)
   );

endmodule

// File: tb/tb_pe_psum_merge.sv
module tb_pe_psum_merge;

   localparam int PW = 8;
   localparam int AW = 8;
   localparam int NN = 20;
   localparam int NW = $clog2(NN);
   localparam int FD = 4;
   localparam int MAXV = (1 << (AW - 1)) - 1;
   localparam int MINV = -(1 << (AW - 1));

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] in_data;
   logic          in_vd;
   logic [NW-1:0] in_node;
   logic          in_last;
   logic          out_ready;
   logic          out_vd;
   logic [AW-1:0] out_data;
   logic [NW-1:0] out_node;
   logic          overflow;
   logic          node_err;

   pe_psum_merge #(
      .PE_OUT_WIDTH (PW),
      .ACC_WIDTH    (AW),
      .NUM_NODES    (NN),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_vd     (in_vd),
      .in_node   (in_node),
      .in_last   (in_last),
      .out_ready (out_ready),
      .out_vd    (out_vd),
      .out_data  (out_data),
      .out_node  (out_node),
      .overflow  (overflow),
      .node_err  (node_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: list of completed results awaiting drain, plus the open node.
   typedef struct {
      int node;
      int sum;
   } res_t;

   res_t exp_q[$];
   bit   m_open;
   int   m_node;
   int   m_sum;
   bit   m_ovf;
   bit   m_err;

   function automatic int acc_add(input int a, input int b);
      int s;
      s = a + b;
`ifdef PSUM_SATURATE_EN
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
`else
      s = ((s - MINV) & ((1 << AW) - 1)) + MINV;
`endif
      return s;
   endfunction

   function automatic logic [AW-1:0] to_acc(input int v);
      return AW'(v);
   endfunction

   // One clock: drive inputs on the falling edge, advance the model, sample 1 time unit after the rising edge.
   task automatic cycle(input bit vd, input int node, input bit last, input int data, input bit rdy);
      bit   pop_m;
      bit   was_full;
      bit   do_push;
      res_t r;
      @(negedge clk);
      reset     = 1'b0;
      in_vd     = vd;
      in_node   = NW'(node);
      in_last   = last;
      in_data   = PW'(data);
      out_ready = rdy;
      was_full  = (exp_q.size() == FD);
      pop_m     = (exp_q.size() > 0) && rdy;
      do_push   = 1'b0;
      r.node    = node;
      r.sum     = 0;
      if (vd) begin
         if (m_open && node != m_node) begin
            m_err  = 1'b1;
            m_open = 1'b0;
         end
         r.sum = m_open ? acc_add(m_sum, data) : data;
         if (last) begin
            do_push = 1'b1;
            m_open  = 1'b0;
         end else begin
            m_open = 1'b1;
            m_node = node;
            m_sum  = r.sum;
         end
      end
      if (pop_m) exp_q.delete(0);
      if (do_push) begin
         if (was_full && !pop_m) m_ovf = 1'b1;
         else exp_q.push_back(r);
      end
      @(posedge clk);
      #1;
   endtask

   // Reset cycle with a valid single-partial node on the inputs; it must be ignored.
   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      in_vd     = 1'b1;
      in_last   = 1'b1;
      in_node   = NW'(3);
      in_data   = 8'h55;
      out_ready = 1'b1;
      exp_q.delete();
      m_open = 1'b0;
      m_ovf  = 1'b0;
      m_err  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_vd !== 1'b0) begin errors++; $display("FAIL reset_out_vd got %0b exp 0", out_vd); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
      checks++; if (out_node !== '0) begin errors++; $display("FAIL reset_out_node got %0d exp 0", out_node); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
      checks++; if (node_err !== 1'b0) begin errors++; $display("FAIL reset_node_err got %0b exp 0", node_err); end
      cycle(0, 0, 0, 0, 1);
      checks++; if (out_vd !== 1'b0) begin errors++; $display("FAIL reset_input_ignored out_vd got %0b exp 0", out_vd); end
   endtask

   task automatic test_basic();
      do_reset();
      cycle(1, 3, 0, 5, 1);
      checks++; if (out_vd !== 1'b0) begin errors++; $display("FAIL basic_open1 out_vd got %0b exp 0", out_vd); end
      cycle(1, 3, 0, -2, 1);
      checks++; if (out_vd !== 1'b0) begin errors++; $display("FAIL basic_open2 out_vd got %0b exp 0", out_vd); end
      cycle(1, 3, 1, 7, 1);
      checks++; if (out_vd !== 1'b1) begin errors++; $display("FAIL basic_vd got %0b exp 1", out_vd); end
      checks++; if (out_node !== NW'(3)) begin errors++; $display("FAIL basic_node got %0d exp 3", out_node); end
      checks++; if (out_data !== AW'(10)) begin errors++; $display("FAIL basic_data got %0d exp 10", out_data); end
      cycle(0, 0, 0, 0, 1);
      checks++; if (out_vd !== 1'b0) begin errors++; $display("FAIL basic_drained out_vd got %0b exp 0", out_vd); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         cycle(1, i, 1, i * 10, 0);
         if (i == 4) begin
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_four got %0b exp 0", overflow); end
         end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
      checks++; if (node_err !== 1'b0) begin errors++; $display("FAIL ovf_node_err got %0b exp 0", node_err); end
      for (int i = 1; i <= 4; i++) begin
         checks++; if (out_vd !== 1'b1) begin errors++; $display("FAIL ovf_drain_vd[%0d] got %0b exp 1", i, out_vd); end
         checks++; if (out_node !== NW'(i)) begin errors++; $display("FAIL ovf_drain_node[%0d] got %0d exp %0d", i, out_node, i); end
         checks++; if (out_data !== to_acc(i * 10)) begin errors++; $display("FAIL ovf_drain_data[%0d] got %0d exp %0d", i, out_data, i * 10); end
         cycle(0, 0, 0, 0, 1);
      end
      checks++; if (out_vd !== 1'b0) begin errors++; $display("FAIL ovf_empty out_vd got %0b exp 0", out_vd); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
   endtask

   task automatic test_node_err();
      do_reset();
      cycle(1, 2, 0, 4, 1);
      cycle(1, 2, 0, 4, 1);
      checks++; if (node_err !== 1'b0) begin errors++; $display("FAIL err_early got %0b exp 0", node_err); end
      cycle(1, 6, 1, 9, 1);
      checks++; if (node_err !== 1'b1) begin errors++; $display("FAIL err_flag got %0b exp 1", node_err); end
      checks++; if (out_vd !== 1'b1) begin errors++; $display("FAIL err_vd got %0b exp 1", out_vd); end
      checks++; if (out_node !== NW'(6)) begin errors++; $display("FAIL err_node got %0d exp 6", out_node); end
      checks++; if (out_data !== AW'(9)) begin errors++; $display("FAIL err_data got %0d exp 9", out_data); end
      cycle(0, 0, 0, 0, 1);
      checks++; if (out_vd !== 1'b0) begin errors++; $display("FAIL err_no_node2 out_vd got %0b exp 0", out_vd); end
   endtask

   task automatic test_saturate();
      logic [AW-1:0] exp_hi;
      logic [AW-1:0] exp_lo;
`ifdef PSUM_SATURATE_EN
      exp_hi = 8'h7f;
      exp_lo = 8'h80;
`else
      exp_hi = 8'h80;
      exp_lo = 8'h7f;
`endif
      do_reset();
      cycle(1, 0, 0, 127, 1);
      cycle(1, 0, 1, 1, 1);
      checks++; if (out_data !== exp_hi) begin errors++; $display("FAIL sat_pos got %0h exp %0h", out_data, exp_hi); end
      cycle(1, 1, 0, -128, 1);
      cycle(1, 1, 1, -1, 1);
      checks++; if (out_node !== NW'(1)) begin errors++; $display("FAIL sat_neg_node got %0d exp 1", out_node); end
      checks++; if (out_data !== exp_lo) begin errors++; $display("FAIL sat_neg got %0h exp %0h", out_data, exp_lo); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_no_ovf got %0b exp 0", overflow); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cycle(1, 1, 1, 11, 0);
      cycle(1, 2, 1, 12, 0);
      cycle(1, 4, 0, 5, 0);
      cycle(1, 5, 0, 1, 0);
      checks++; if (out_vd !== 1'b1) begin errors++; $display("FAIL rmid_pre_vd got %0b exp 1", out_vd); end
      checks++; if (node_err !== 1'b1) begin errors++; $display("FAIL rmid_pre_err got %0b exp 1", node_err); end
      do_reset();
      checks++; if (out_vd !== 1'b0) begin errors++; $display("FAIL rmid_vd got %0b exp 0", out_vd); end
      checks++; if (node_err !== 1'b0) begin errors++; $display("FAIL rmid_err got %0b exp 0", node_err); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %0b exp 0", overflow); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL rmid_data got %0h exp 0", out_data); end
      cycle(1, 7, 1, 3, 1);
      checks++; if (out_node !== NW'(7)) begin errors++; $display("FAIL rmid_node7 got %0d exp 7", out_node); end
      checks++; if (out_data !== AW'(3)) begin errors++; $display("FAIL rmid_data7 got %0d exp 3", out_data); end
      // Node 5 was open before reset; its earlier partial must be gone.
      cycle(1, 5, 1, 2, 1);
      checks++; if (out_node !== NW'(5)) begin errors++; $display("FAIL rmid_node5 got %0d exp 5", out_node); end
      checks++; if (out_data !== AW'(2)) begin errors++; $display("FAIL rmid_data5 got %0d exp 2", out_data); end
      checks++; if (node_err !== 1'b0) begin errors++; $display("FAIL rmid_err_after got %0b exp 0", node_err); end
   endtask

   task automatic test_full_pushpop();
      do_reset();
      for (int i = 10; i <= 13; i++) cycle(1, i, 1, i + 20, 0);
      checks++; if (out_node !== NW'(10)) begin errors++; $display("FAIL fpp_head0 got %0d exp 10", out_node); end
      cycle(1, 14, 1, 34, 1);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %0b exp 0", overflow); end
      for (int i = 11; i <= 14; i++) begin
         checks++; if (out_vd !== 1'b1) begin errors++; $display("FAIL fpp_vd[%0d] got %0b exp 1", i, out_vd); end
         checks++; if (out_node !== NW'(i)) begin errors++; $display("FAIL fpp_node[%0d] got %0d exp %0d", i, out_node, i); end
         checks++; if (out_data !== to_acc(i + 20)) begin errors++; $display("FAIL fpp_data[%0d] got %0d exp %0d", i, out_data, i + 20); end
         cycle(0, 0, 0, 0, 1);
      end
      checks++; if (out_vd !== 1'b0) begin errors++; $display("FAIL fpp_empty got %0b exp 0", out_vd); end
   endtask

   task automatic test_random();
      bit vd;
      bit last;
      bit rdy;
      int node;
      int data;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         vd   = ($urandom_range(0, 9) < 7);
         if (m_open && $urandom_range(0, 19) != 0) node = m_node;
         else node = int'($urandom_range(0, NN - 1));
         last = ($urandom_range(0, 3) == 0);
         rdy  = ($urandom_range(0, 9) < 4);
         data = int'($urandom_range(0, 255)) - 128;
         cycle(vd, node, last, data, rdy);
         checks++; if (out_vd !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_vd[%0d] got %0b exp %0b", n, out_vd, exp_q.size() > 0); end
         if (exp_q.size() > 0) begin
            checks++; if (out_node !== NW'(exp_q[0].node)) begin errors++; $display("FAIL rnd_node[%0d] got %0d exp %0d", n, out_node, exp_q[0].node); end
            checks++; if (out_data !== to_acc(exp_q[0].sum)) begin errors++; $display("FAIL rnd_data[%0d] got %0h exp %0h", n, out_data, to_acc(exp_q[0].sum)); end
         end
         checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %0b exp %0b", n, overflow, m_ovf); end
         checks++; if (node_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got %0b exp %0b", n, node_err, m_err); end
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_vd     = 1'b0;
      in_node   = '0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      m_open    = 1'b0;
      m_node    = 0;
      m_sum     = 0;
      m_ovf     = 1'b0;
      m_err     = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_node_err();
      test_saturate();
      test_reset_mid();
      test_full_pushpop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
